// File: rtl/shift_seq_pkg.sv
// Shared types and widths for the button-driven rotate sequencer.
package shift_seq_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        HOLD
    } state_t;

    typedef enum logic {
        DIR_R,
        DIR_L
    } dir_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Link between the sequencer and the combinational rotator at board top.
interface shift_sequencer_if;
    import shift_seq_pkg::*;

    logic [DATA_W-1:0] sh_data;
    logic              sh_right;
    logic              sh_left;
    logic              sh_double;
    logic [DATA_W-1:0] sh_result;

    // Sequencer side: drives the operand and selects, captures the result.
    modport master (
        output sh_data, sh_right, sh_left, sh_double,
        input  sh_result
    );

    // Rotator side.
    modport slave (
        input  sh_data, sh_right, sh_left, sh_double,
        output sh_result
    );
endinterface

// File: rtl/debouncer.sv
// Push-button debouncer: the level follows the raw input only after the
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             level_q;

    // Count consecutive disagreeing samples; any agreement restarts the count.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            level_q <= level;
            if (raw != level) begin
                if (cnt == CNT_LAST) begin
                    level <= raw;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // Single-cycle pulse in the first cycle the debounced level is high.
    assign rise = level & ~level_q;

endmodule

// File: rtl/shift_sequencer.sv
// Debounces the board buttons, loads an operand from the switches and steps
// the external rotator one operation per press, auto-repeating while held.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_CYCLES   = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  sw,
    input  logic               btnr,
    input  logic               btnl,
    input  logic               btnc,
    input  logic               btnd,
    shift_sequencer_if.master  sh,
    output logic [DATA_W-1:0]  led,
    output logic [7:0]         shift_count,
    output logic               busy
);
    localparam int REP_W = $clog2(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic r_level, r_rise;
    logic l_level, l_rise;
    logic c_level, unused_c_rise;   // btnc only scales the amount; its edge is not needed
    logic d_level, d_rise;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk(clk), .rst(rst), .raw(btnr), .level(r_level), .rise(r_rise)
    );
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk(clk), .rst(rst), .raw(btnl), .level(l_level), .rise(l_rise)
    );
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_c (
        .clk(clk), .rst(rst), .raw(btnc), .level(c_level), .rise(unused_c_rise)
    );
    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_d (
        .clk(clk), .rst(rst), .raw(btnd), .level(d_level), .rise(d_rise)
    );

    state_t           state;
    dir_t             dir;
    logic [REP_W-1:0] rep_cnt;
    logic             sel_r;
    logic             sel_l;
    logic             held;
    logic             unused_d_level;

    assign unused_d_level = d_level;
    assign held           = (dir == DIR_R) ? r_level : l_level;

    // Sequencer FSM with registered busy and direction selects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dir         <= DIR_R;
            rep_cnt     <= '0;
            led         <= '0;
            shift_count <= '0;
            sel_r       <= 1'b0;
            sel_l       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_rise) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end else if ((r_rise || l_rise) && !(r_level && l_level)) begin
                        // Both directions held at once is ambiguous, so it is ignored.
                        state <= SHIFT;
                        busy  <= 1'b1;
                        dir   <= r_rise ? DIR_R : DIR_L;
                        sel_r <= r_rise;
                        sel_l <= ~r_rise;
                    end
                end
                LOAD: begin
                    led   <= sw;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                SHIFT: begin
                    led         <= sh.sh_result;
                    shift_count <= shift_count + 8'd1;
                    rep_cnt     <= '0;
                    sel_r       <= 1'b0;
                    sel_l       <= 1'b0;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (!held) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (rep_cnt == REP_LAST) begin
                        state <= SHIFT;
                        sel_r <= (dir == DIR_R);
                        sel_l <= (dir == DIR_L);
                    end else begin
                        rep_cnt <= rep_cnt + REP_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The rotator always sees the operand register; by-2 follows btnc live in SHIFT.
    assign sh.sh_data   = led;
    assign sh.sh_right  = sel_r;
    assign sh.sh_left   = sel_l;
    assign sh.sh_double = (sel_r | sel_l) & c_level;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural rotator.
module tb_shift_sequencer;
    import shift_seq_pkg::*;

    localparam int D = 4;
    localparam int R = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = '0;
    logic        btnr = 1'b0, btnl = 1'b0, btnc = 1'b0, btnd = 1'b0;
    logic [15:0] led;
    logic [7:0]  shift_count;
    logic        busy;

    shift_sequencer_if bus ();

    // Behavioural rotator at board level.
    logic [31:0] dd;
    always_comb begin
        dd = {bus.sh_data, bus.sh_data};
        if (bus.sh_right)
            bus.sh_result = 16'(dd >> (bus.sh_double ? 2 : 1));
        else if (bus.sh_left)
            bus.sh_result = 16'((dd << (bus.sh_double ? 2 : 1)) >> 16);
        else
            bus.sh_result = bus.sh_data;
    end

    shift_sequencer #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btnr(btnr), .btnl(btnl), .btnc(btnc), .btnd(btnd),
        .sh(bus), .led(led), .shift_count(shift_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int shift_cycles = 0;
    int dbl_cycles = 0;
    logic [7:0] exp_count = 8'd0;

    // Count rotator activity on the inactive edge.
    always @(negedge clk) begin
        if (bus.sh_right || bus.sh_left) shift_cycles++;
        if (bus.sh_double) dbl_cycles++;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference rotation, one bit at a time.
    function automatic logic [15:0] ref_rot(input logic [15:0] x, input bit right, input int n);
        logic [15:0] y;
        y = x;
        for (int k = 0; k < n; k++)
            y = right ? {y[0], y[15:1]} : {y[14:0], y[15]};
        return y;
    endfunction

    task automatic do_load(input logic [15:0] v);
        sw = v;
        btnd = 1'b1;
        tick(D + 2);
        btnd = 1'b0;
        tick(D + 2);
    endtask

    task automatic test_reset;
        tick(2);
        checks++;
        if (led !== 16'h0000 || shift_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: led=%h cnt=%0d busy=%b expected 0000/0/0", led, shift_count, busy);
        end
        checks++;
        if ({bus.sh_right, bus.sh_left, bus.sh_double} !== 3'b000 || bus.sh_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_sh: sel=%b data=%h expected 000/0000",
                     {bus.sh_right, bus.sh_left, bus.sh_double}, bus.sh_data);
        end
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_load;
        sw = 16'hA5C3;
        btnd = 1'b1;
        tick(D);
        checks++;
        if (busy !== 1'b0 || led !== 16'h0000) begin
            errors++;
            $display("FAIL load_pulse_cycle: busy=%b led=%h expected 0/0000", busy, led);
        end
        tick(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL load_busy: got %b expected 1", busy);
        end
        tick(1);
        checks++;
        if (led !== 16'hA5C3 || shift_count !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL load_led: led=%h cnt=%0d busy=%b expected a5c3/0/0", led, shift_count, busy);
        end
        btnd = 1'b0;
        tick(D + 2);
    endtask

    task automatic test_shift_right;
        do_load(16'h8001);
        shift_cycles = 0;
        btnr = 1'b1;
        tick(D + 1);
        checks++;
        if ({bus.sh_right, bus.sh_left, bus.sh_double} !== 3'b100 || bus.sh_data !== 16'h8001) begin
            errors++;
            $display("FAIL right_shift_cycle: sel=%b data=%h expected 100/8001",
                     {bus.sh_right, bus.sh_left, bus.sh_double}, bus.sh_data);
        end
        tick(1);
        exp_count++;
        checks++;
        if (led !== 16'hC000 || shift_count !== exp_count) begin
            errors++;
            $display("FAIL right_result: led=%h cnt=%0d expected c000/%0d", led, shift_count, exp_count);
        end
        btnr = 1'b0;
        tick(D + R);
        checks++;
        if (shift_cycles !== 1 || led !== 16'hC000 || busy !== 1'b0 || shift_count !== exp_count) begin
            errors++;
            $display("FAIL right_single: shifts=%0d led=%h busy=%b cnt=%0d expected 1/c000/0/%0d",
                     shift_cycles, led, busy, shift_count, exp_count);
        end
    endtask

    task automatic test_double_left;
        do_load(16'h8001);
        shift_cycles = 0;
        dbl_cycles = 0;
        btnc = 1'b1;
        tick(D + 3);
        checks++;
        if (busy !== 1'b0 || shift_cycles !== 0) begin
            errors++;
            $display("FAIL btnc_alone: busy=%b shifts=%0d expected 0/0", busy, shift_cycles);
        end
        btnl = 1'b1;
        tick(D + 1);
        checks++;
        if ({bus.sh_right, bus.sh_left, bus.sh_double} !== 3'b011) begin
            errors++;
            $display("FAIL dbl_shift_cycle: sel=%b expected 011", {bus.sh_right, bus.sh_left, bus.sh_double});
        end
        tick(1);
        exp_count++;
        checks++;
        if (led !== 16'h0006 || shift_count !== exp_count) begin
            errors++;
            $display("FAIL dbl_result: led=%h cnt=%0d expected 0006/%0d", led, shift_count, exp_count);
        end
        btnl = 1'b0;
        btnc = 1'b0;
        tick(D + R);
        checks++;
        if (dbl_cycles !== 1 || shift_cycles !== 1) begin
            errors++;
            $display("FAIL dbl_once: dbl=%0d shifts=%0d expected 1/1", dbl_cycles, shift_cycles);
        end
    endtask

    task automatic test_bounce;
        logic [15:0] led_before;
        led_before = led;
        shift_cycles = 0;
        repeat (5) begin
            btnr = 1'b1;
            tick(2);
            btnr = 1'b0;
            tick(2);
        end
        tick(D + R);
        checks++;
        if (shift_cycles !== 0 || led !== led_before || shift_count !== exp_count || busy !== 1'b0) begin
            errors++;
            $display("FAIL bounce: shifts=%0d led=%h cnt=%0d busy=%b expected 0/%h/%0d/0",
                     shift_cycles, led, shift_count, busy, led_before, exp_count);
        end
    endtask

    task automatic test_auto_repeat;
        logic [15:0] exp_led;
        do_load(16'h0001);
        exp_led = 16'h0001;
        shift_cycles = 0;
        btnl = 1'b1;
        tick(D + 1);                       // pulse + 1: first SHIFT cycle
        for (int k = 0; k < 4; k++) begin
            tick(1);                       // pulse + 2 + 9k
            exp_led = ref_rot(exp_led, 1'b0, 1);
            exp_count++;
            checks++;
            if (led !== exp_led || shift_count !== exp_count) begin
                errors++;
                $display("FAIL repeat_%0d: led=%h cnt=%0d expected %h/%0d", k, led, shift_count, exp_led, exp_count);
            end
            if (k < 3) begin
                tick(R);                   // pulse + 10 + 9k: next SHIFT, led not yet updated
                checks++;
                if (led !== exp_led || bus.sh_left !== 1'b1) begin
                    errors++;
                    $display("FAIL repeat_pre_%0d: led=%h sh_left=%b expected %h/1", k, led, bus.sh_left, exp_led);
                end
            end
        end
        tick(1);
        btnl = 1'b0;
        tick(D + R + 2);
        checks++;
        if (led !== 16'h0010 || shift_count !== exp_count || shift_cycles !== 4 || busy !== 1'b0) begin
            errors++;
            $display("FAIL repeat_end: led=%h cnt=%0d shifts=%0d busy=%b expected 0010/%0d/4/0",
                     led, shift_count, shift_cycles, busy, exp_count);
        end
    endtask

    task automatic test_both;
        logic [15:0] led_before;
        led_before = led;
        shift_cycles = 0;
        btnr = 1'b1;
        btnl = 1'b1;
        tick(D + 2);
        checks++;
        if (busy !== 1'b0 || shift_cycles !== 0) begin
            errors++;
            $display("FAIL both_buttons: busy=%b shifts=%0d expected 0/0", busy, shift_cycles);
        end
        btnr = 1'b0;
        btnl = 1'b0;
        tick(D + 2);
        checks++;
        if (led !== led_before || shift_count !== exp_count) begin
            errors++;
            $display("FAIL both_state: led=%h cnt=%0d expected %h/%0d", led, shift_count, led_before, exp_count);
        end
    endtask

    task automatic test_reset_mid_shift;
        do_load(16'h1234);
        btnr = 1'b1;
        tick(D + 1);
        checks++;
        if (bus.sh_right !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_shift_setup: sh_right=%b busy=%b expected 1/1", bus.sh_right, busy);
        end
        #2 rst = 1'b1;
        #1;
        exp_count = 8'd0;
        checks++;
        if (led !== 16'h0000 || shift_count !== 8'd0 || busy !== 1'b0 || bus.sh_right !== 1'b0) begin
            errors++;
            $display("FAIL mid_shift_reset: led=%h cnt=%0d busy=%b sh_right=%b expected 0000/0/0/0",
                     led, shift_count, busy, bus.sh_right);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        tick(D + 1);
        checks++;
        if (shift_count !== 8'd0 || bus.sh_right !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_redebounce: cnt=%0d sh_right=%b expected 0/1", shift_count, bus.sh_right);
        end
        tick(1);
        exp_count++;
        checks++;
        if (shift_count !== exp_count || led !== 16'h0000) begin
            errors++;
            $display("FAIL post_reset_shift: cnt=%0d led=%h expected %0d/0000", shift_count, led, exp_count);
        end
        btnr = 1'b0;
        tick(D + 2);
    endtask

    task automatic test_random;
        logic [15:0] v, exp_led;
        bit          right, dbl;
        for (int i = 0; i < 8; i++) begin
            v     = 16'($urandom);
            right = 1'($urandom_range(0, 1));
            dbl   = 1'($urandom_range(0, 1));
            do_load(v);
            if (dbl) begin
                btnc = 1'b1;
                tick(D + 1);
            end
            if (right) btnr = 1'b1;
            else       btnl = 1'b1;
            tick(D + 2);
            exp_led = ref_rot(v, right, dbl ? 2 : 1);
            exp_count++;
            checks++;
            if (led !== exp_led || shift_count !== exp_count) begin
                errors++;
                $display("FAIL random_%0d: v=%h r=%b d=%b led=%h cnt=%0d expected %h/%0d",
                         i, v, right, dbl, led, shift_count, exp_led, exp_count);
            end
            btnr = 1'b0;
            btnl = 1'b0;
            btnc = 1'b0;
            tick(D + R);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_shift_right();
        test_double_left();
        test_bounce();
        test_auto_repeat();
        test_both();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Button-driven sequencer for the 16-bit rotate datapath on the lab board. It debounces the raw push-buttons, loads an operand from the slide switches and holds it in a register. It steps the combinational rotator one operation per press, with auto-repeat while a direction button is held. It sits between the board I/O (switches, buttons, LEDs) and the rotator: it drives the rotator's operand and controls and captures its result.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable samples needed before a debounced level changes (≥2).
- REPEAT_CYCLES, 50_000_000: HOLD-state cycles between auto-repeat shifts (≥2).

Ports:
- clk  in  1  system clock; the block uses only this one clock.
- rst  in  1  reset, asynchronous and active-high.
- sw  in  16  operand source.
- btnr  in  1  raw button, rotate right.
- btnl  in  1  raw button, rotate left.
- btnc  in  1  raw button; held = rotate by 2 instead of 1.
- btnd  in  1  raw button, load sw into register.
- sh_data  out  16  operand to rotator; always equals led.
- sh_right  out  1  rotator right-select; high only in SHIFT.
- sh_left  out  1  rotator left-select; high only in SHIFT.
- sh_double  out  1  rotator by-2 select; high only in SHIFT.
- sh_result  in  16  rotator output (combinational from the sh_* signals).
- led  out  16  operand register.
- shift_count  out  8  number of completed shifts, wraps 255→0.
- busy  out  1  high in LOAD, SHIFT, HOLD.

## Operation
- Each raw button passes through its own debouncer. The debounced level flips after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Rise pulse = debounced level high this cycle, low last cycle. Each qualifying press produces exactly one pulse.
- FSM states: IDLE, LOAD, SHIFT, HOLD.
  - IDLE → LOAD on the btnd rise pulse. Load has priority over a simultaneous direction pulse.
  - IDLE → SHIFT on the btnr or btnl rise pulse. The direction is latched. If both debounced levels are high, the pulse is ignored and the FSM stays in IDLE.
  - LOAD: led ← sw; → IDLE.
  - SHIFT: drive the latched direction select. sh_double = debounced btnc level. At the end of the cycle: led ← sh_result, shift_count +1, repeat counter cleared; → HOLD.
  - HOLD: while the latched direction button stays debounced-high, the repeat counter increments. When it reaches REPEAT_CYCLES-1, → SHIFT. On release of the latched button → IDLE. Other buttons are ignored in HOLD.
- btnc only modifies the shift amount; it never starts a shift.
- Reset values: led = 16'h0000, shift_count = 0, busy = 0, sh_* selects = 0, FSM = IDLE, all debounced levels 0, all counters 0.

## Timing
- A raw press stable from cycle t gives debounced level high at t+DEBOUNCE_CYCLES, and the rise pulse in that same cycle.
- SHIFT occupies the cycle after the pulse. led and shift_count update on the clock edge ending SHIFT, so the new value is visible 2 cycles after the pulse.
- LOAD follows the same timing: led equals sw (sampled in the LOAD cycle) 2 cycles after the pulse.
- Auto-repeat period while held: REPEAT_CYCLES+1 cycles per shift (REPEAT_CYCLES in HOLD plus 1 SHIFT).
- Release during HOLD: IDLE on the next edge; no further shift.
- Asynchronous reset mid-SHIFT: the shift is aborted, led = 0 immediately, and no count increment. After reset deasserts, a button still held shows as a fresh press only after debouncing, because the debounced level restarts from 0.
- The rotator is combinational: sh_result must settle within one clk period. There is no handshake.

## Structure
- Package shift_seq_pkg: the state enum type (IDLE, LOAD, SHIFT, HOLD), a direction enum (DIR_R, DIR_L), and DATA_W = 16.
- Sub-module debouncer, parameterized by DEBOUNCE_CYCLES: inputs clk, rst, raw; outputs level and rise. Instantiated four times.
- The rotator is instantiated outside this block, at board top level.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, with a behavioural rotator model.
- Reset, then sw=16'hA5C3 and btnd pulsed clean for 6 cycles → led=16'hA5C3 two cycles after the rise pulse; shift_count=0.
- led=16'h8001, btnr press (btnc low), released before repeat → led=16'hC000, shift_count=1, exactly one SHIFT.
- led=16'h8001, btnc held, then btnl press → led=16'h0006; sh_double high for exactly one cycle.
- btnr raw toggling every 2 cycles for 20 cycles, then low → no rise pulse, led unchanged.
- led=16'h0001, btnl held for 30 cycles after debounce → shifts at +2, +11, +20, +29 cycles after the pulse; led=16'h0010, shift_count=4.
- btnr and btnl pressed together → no shift. Separately, asserting rst in the SHIFT cycle → led=0, shift_count=0, FSM in IDLE.
